// File: rtl/debug_monitor.sv
`timescale 1ns/1ps
// debug_monitor: shows one of NUM_CH packed status channels as hex on six 7-seg digits,
// with debounced KEY control of manual, auto-scroll and freeze modes plus paging of wide channels.
module debug_monitor #(
    parameter int NUM_CH          = 8,
    parameter int CH_WIDTH        = 32,
    parameter int DIGITS          = 6,
    parameter int SCROLL_DIV      = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                         Clock_50,
    input  logic                         Reset,
    input  logic [NUM_CH*CH_WIDTH-1:0]   ch_data,
    input  logic [9:0]                   SW,
    input  logic [3:0]                   KEY,
    output logic [6:0]                   HEX0,
    output logic [6:0]                   HEX1,
    output logic [6:0]                   HEX2,
    output logic [6:0]                   HEX3,
    output logic [6:0]                   HEX4,
    output logic [6:0]                   HEX5,
    output logic [9:0]                   LEDR
);

    localparam int DW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCROLL_DIV - 1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]    NUM_CH_L   = 5'(NUM_CH);
    localparam logic [3:0]    LAST_CH    = 4'(NUM_CH - 1);

    typedef enum logic [1:0] {MANUAL, SCROLL, FREEZE} mode_t;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  4'hF: seg7 = 7'h0E;
        endcase
    endfunction

    // SW[8:4] and KEY[3:2] have no function on this board
    logic unused_inputs;
    assign unused_inputs = ^{SW[8:4], KEY[3:2]};

    // Reset asserts at once but releases on a clock edge so no flop sees a runt recovery
    logic rst_meta_q, rst_q;
    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            rst_meta_q <= 1'b1;
            rst_q      <= 1'b1;
        end else begin
            // NOTE: non-blocking so each stage samples the value from before the edge.
            rst_meta_q <= 1'b0;
            rst_q      <= rst_meta_q;
        end
    end

    logic [1:0]          key_meta_q, key_sync_q;
    logic [1:0]          key_level_q, key_level_d;
    logic [1:0][BW-1:0]  db_cnt_q, db_cnt_d;
    logic [1:0]          press;

    mode_t               mode_q, mode_d, ret_q, ret_d;
    logic [3:0]          idx_q, idx_d;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic                oor_q, oor_d;
    logic                page_q, page_d;
    logic [CH_WIDTH-1:0] snap_q, snap_d, chan;
    logic [31:0]         snap32;
    logic [DIGITS-1:0][6:0] hex_q, hex_d;
    logic [9:0]          ledr_q, ledr_d;

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
        key_level_d = key_level_q;
        db_cnt_d    = db_cnt_q;
        press       = '0;
        for (int k = 0; k < 2; k++) begin
            if (key_sync_q[k] == key_level_q[k]) begin
                db_cnt_d[k] = '0;
            end else if (db_cnt_q[k] == DB_LAST) begin
                db_cnt_d[k]    = '0;
                key_level_d[k] = key_sync_q[k];
                press[k]       = ~key_sync_q[k];
            end else begin
                db_cnt_d[k] = db_cnt_q[k] + 1'b1;
            end
        end
    end

    always_comb begin
        mode_d = mode_q;
        ret_d  = ret_q;
        case (mode_q)
            MANUAL, SCROLL: begin
                if (press[0]) begin
                    mode_d = FREEZE;
                    ret_d  = mode_q;
                end else if (press[1]) begin
                    mode_d = (mode_q == MANUAL) ? SCROLL : MANUAL;
                end
            end
            FREEZE:  if (press[0]) mode_d = ret_q;
            default: mode_d = MANUAL;
        endcase
    end

    // Index and snapshot follow the next mode so a freeze keeps the value captured before the press
    always_comb begin
        idx_d   = idx_q;
        dwell_d = dwell_q;
        oor_d   = oor_q;
        case (mode_d)
            MANUAL: begin
                idx_d   = SW[3:0];
                dwell_d = '0;
                oor_d   = {1'b0, SW[3:0]} >= NUM_CH_L;
            end
            SCROLL: begin
                oor_d = 1'b0;
                if (mode_q == MANUAL) begin
                    dwell_d = '0;
                    idx_d   = ({1'b0, idx_q} >= NUM_CH_L) ? 4'd0 : idx_q;
                end else if (mode_q == SCROLL) begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        idx_d   = (idx_q >= LAST_CH) ? 4'd0 : idx_q + 4'd1;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        chan = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx_d == 4'(i)) chan = ch_data[i*CH_WIDTH +: CH_WIDTH];
        end
        snap_d = (mode_d == FREEZE) ? snap_q : chan;
        page_d = SW[9];
    end

    assign snap32 = 32'(snap_q);

    always_comb begin
        hex_d = '1;
        for (int d = 0; d < DIGITS; d++) begin
            if (!page_q) begin
                hex_d[d] = seg7(snap32[4*d +: 4]);
            end else if (d < 2) begin
                hex_d[d] = seg7((d == 1) ? snap32[31:28] : snap32[27:24]);
            end
        end
        ledr_d = {mode_q == FREEZE, mode_q == SCROLL, 1'b0, oor_q, 2'b00, idx_q};
    end

    always_ff @(posedge Clock_50 or posedge rst_q) begin
        if (rst_q) begin
            key_meta_q  <= 2'b11;
            key_sync_q  <= 2'b11;
            key_level_q <= 2'b11;
            db_cnt_q    <= '0;
            mode_q      <= MANUAL;
            ret_q       <= MANUAL;
            idx_q       <= '0;
            dwell_q     <= '0;
            oor_q       <= 1'b0;
            page_q      <= 1'b0;
            snap_q      <= '0;
            hex_q       <= '1;
            ledr_q      <= '0;
        end else begin
            key_meta_q  <= KEY[1:0];
            key_sync_q  <= key_meta_q;
            key_level_q <= key_level_d;
            db_cnt_q    <= db_cnt_d;
            mode_q      <= mode_d;
            ret_q       <= ret_d;
            idx_q       <= idx_d;
            dwell_q     <= dwell_d;
            oor_q       <= oor_d;
            page_q      <= page_d;
            snap_q      <= snap_d;
            hex_q       <= hex_d;
            ledr_q      <= ledr_d;
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
    assign LEDR = ledr_q;

endmodule

// File: tb/tb_debug_monitor.sv
`timescale 1ns/1ps
// Bench for debug_monitor: vector table in manual mode, randomized manual traffic against
// a reference model, and hand-written KEY/scroll/freeze/reset sequences.
module tb_debug_monitor;

    localparam int NUM_CH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  ch [NUM_CH];
    logic [127:0] ch_data;
    logic [9:0]   sw;
    logic [3:0]   key;
    logic [6:0]   hex0, hex1, hex2, hex3, hex4, hex5;
    logic [9:0]   ledr;
    logic [41:0]  hex_bus;

    int n_cmp = 0;
    int n_bad = 0;

    assign ch_data = {ch[3], ch[2], ch[1], ch[0]};
    assign hex_bus = {hex5, hex4, hex3, hex2, hex1, hex0};

    always #10 clk = ~clk;

    debug_monitor #(
        .NUM_CH(NUM_CH), .CH_WIDTH(32), .DIGITS(6), .SCROLL_DIV(8), .DEBOUNCE_CYCLES(4)
    ) dut (
        .Clock_50(clk), .Reset(rst), .ch_data(ch_data), .SW(sw), .KEY(key),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5),
        .LEDR(ledr)
    );

    logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [9:0]  sw;
        logic [41:0] hex;
        logic [9:0]  ledr;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [41:0] model_hex(input logic [31:0] v, input logic page);
        logic [41:0] r;
        logic [3:0]  nib;
        r = '1;
        for (int d = 0; d < 6; d++) begin
            if (!page) begin
                nib = 4'((v >> (4 * d)) & 32'hF);
                r[7*d +: 7] = seg_lut[nib];
            end else if (d < 2) begin
                nib = 4'((v >> (24 + 4 * d)) & 32'hF);
                r[7*d +: 7] = seg_lut[nib];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] model_snap(input logic [3:0] idx);
        return (int'(idx) < NUM_CH) ? ch[idx] : 32'h0;
    endfunction

    function automatic logic [9:0] model_ledr(input logic [3:0] idx, input logic oor,
                                              input logic scroll, input logic freeze);
        logic [9:0] r;
        r      = '0;
        r[3:0] = idx;
        r[6]   = oor;
        r[8]   = scroll;
        r[9]   = freeze;
        return r;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_led(input int b, input logic v, input int budget, input string name);
        int w = 0;
        while (ledr[b] !== v && w < budget) begin
            tick(1);
            w++;
        end
        check(name, 64'(ledr[b]), 64'(v));
    endtask

    task automatic set_channels();
        ch[0] = 32'hC3000000;
        ch[1] = 32'h00ABCDEF;
        ch[2] = 32'h12345678;
        ch[3] = 32'h0F1E2D3C;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n, n_f, fi, w;
        logic [31:0] old_val;

        vecs[0] = '{10'h001, {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 10'h001};
        vecs[1] = '{10'h000, {6{7'h40}}, 10'h000};
        vecs[2] = '{10'h200, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h46, 7'h30}, 10'h000};
        vecs[3] = '{10'h005, {6{7'h40}}, 10'h045};
        vecs[4] = '{10'h002, {7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 10'h002};
        vecs[5] = '{10'h203, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h0E}, 10'h003};
        vecs[6] = '{10'h20F, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40}, 10'h04F};
        vecs[7] = '{10'h003, {7'h79, 7'h06, 7'h24, 7'h21, 7'h30, 7'h46}, 10'h003};

        rst = 1'b1;
        sw  = '0;
        key = 4'hF;
        set_channels();
        tick(3);
        check("reset_hex", 64'(hex_bus), 64'({6{7'h7F}}));
        check("reset_ledr", 64'(ledr), 64'h0);
        rst = 1'b0;
        tick(6);

        // Manual-mode table, including the exact two-cycle latency
        for (int i = 0; i < 8; i++) begin
            sw = vecs[i].sw;
            tick(1);
            if (i > 0) begin
                check("latency_hold_hex", 64'(hex_bus), 64'(vecs[i-1].hex));
                check("latency_hold_ledr", 64'(ledr), 64'(vecs[i-1].ledr));
            end
            tick(1);
            check($sformatf("vec%0d_hex", i), 64'(hex_bus), 64'(vecs[i].hex));
            check($sformatf("vec%0d_ledr", i), 64'(ledr), 64'(vecs[i].ledr));
        end

        // Randomized manual traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < NUM_CH; j++) ch[j] = $urandom;
            sw = 10'($urandom);
            if (i % 3 != 0) sw[3:0] = 4'($urandom_range(0, NUM_CH - 1));
            tick(2);
            check("rand_hex", 64'(hex_bus), 64'(model_hex(model_snap(sw[3:0]), sw[9])));
            check("rand_ledr", 64'(ledr),
                  64'(model_ledr(sw[3:0], int'(sw[3:0]) >= NUM_CH, 1'b0, 1'b0)));
        end
        set_channels();

        // Short KEY1 glitch must not register
        sw = 10'h001;
        tick(3);
        key[1] = 1'b0;
        tick(3);
        key[1] = 1'b1;
        tick(15);
        check("short_press_no_scroll", 64'(ledr[9:8]), 64'h0);

        // Proper KEY1 press enters SCROLL from index 1, stepping every 8 cycles
        key[1] = 1'b0;
        tick(6);
        key[1] = 1'b1;
        wait_led(8, 1'b1, 20, "scroll_entry");
        n = 0;
        for (int k = 0; k < 40; k++) begin
            fi = (1 + n / 8) % NUM_CH;
            check("scroll_idx", 64'(ledr[3:0]), 64'(fi));
            check("scroll_mode", 64'(ledr[9:8]), 64'h1);
            check("scroll_hex", 64'(hex_bus), 64'(model_hex(ch[fi], 1'b0)));
            tick(1);
            n++;
        end

        // Freeze during scroll holds the snapshot captured before the press
        key[0] = 1'b0;
        w = 0;
        while (ledr[9] !== 1'b1 && w < 20) begin
            tick(1);
            n++;
            w++;
        end
        key[0] = 1'b1;
        check("freeze_entry", 64'(ledr[9:8]), 64'h2);
        n_f = n;
        fi = (1 + (n_f - 1) / 8) % NUM_CH;
        check("freeze_idx", 64'(ledr[3:0]), 64'(fi));
        check("freeze_hex", 64'(hex_bus), 64'(model_hex(ch[fi], 1'b0)));
        old_val = ch[fi];
        ch[fi] = 32'hFEDC0123;
        tick(5);
        check("frozen_hex_held", 64'(hex_bus), 64'(model_hex(old_val, 1'b0)));
        check("frozen_idx_held", 64'(ledr[3:0]), 64'(fi));
        sw = 10'h200;
        tick(2);
        check("frozen_page1", 64'(hex_bus), 64'(model_hex(old_val, 1'b1)));
        sw = 10'h001;
        tick(2);
        check("frozen_page0", 64'(hex_bus), 64'(model_hex(old_val, 1'b0)));

        key[0] = 1'b0;
        wait_led(9, 1'b0, 20, "unfreeze");
        key[0] = 1'b1;
        check("unfreeze_to_scroll", 64'(ledr[8]), 64'h1);
        check("unfreeze_idx", 64'(ledr[3:0]), 64'(fi));
        check("unfreeze_new_value", 64'(hex_bus), 64'(model_hex(32'hFEDC0123, 1'b0)));
        tick(10);

        key[1] = 1'b0;
        wait_led(8, 1'b0, 20, "scroll_exit");
        key[1] = 1'b1;
        set_channels();
        tick(10);
        check("manual_again_ledr", 64'(ledr), 64'h001);
        check("manual_again_hex", 64'(hex_bus), 64'(model_hex(ch[1], 1'b0)));

        // KEY0 and KEY1 accepted together: freeze wins
        key[1:0] = 2'b00;
        tick(6);
        key[1:0] = 2'b11;
        wait_led(9, 1'b1, 20, "both_keys_freeze");
        check("both_keys_no_scroll", 64'(ledr[8]), 64'h0);
        tick(12);
        check("both_keys_settled", 64'(ledr[9:8]), 64'h2);
        key[1] = 1'b0;
        tick(6);
        key[1] = 1'b1;
        tick(12);
        check("key1_ignored_in_freeze", 64'(ledr[9:8]), 64'h2);

        // Holding KEY0 toggles once; the release is not a press
        key[0] = 1'b0;
        tick(40);
        check("hold_no_repeat", 64'(ledr[9:8]), 64'h0);
        key[0] = 1'b1;
        tick(12);
        check("release_no_press", 64'(ledr), 64'h001);

        // Reset mid-scroll with KEY0 partly debounced
        sw = 10'h000;
        key[1] = 1'b0;
        tick(6);
        key[1] = 1'b1;
        wait_led(8, 1'b1, 20, "scroll_before_reset");
        tick(10);
        key[0] = 1'b0;
        tick(4);
        rst = 1'b1;
        #1;
        check("reset_mid_hex", 64'(hex_bus), 64'({6{7'h7F}}));
        check("reset_mid_ledr", 64'(ledr), 64'h0);
        key[0] = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(20);
        check("post_reset_ledr", 64'(ledr), 64'h0);
        check("post_reset_hex", 64'(hex_bus), 64'(model_hex(ch[0], 1'b0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
